// File: rtl/eva_ahb2apb_pkg.sv
// Shared AHB definitions: transfer/response encodings, legal size and the
// AHB-to-APB bridge state enum. Later AHB blocks import this package too.
package eva_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLAT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_e;

    // Only word-sized, word-aligned transfers reach the APB side.
    function automatic logic is_legal_xfer(input logic [2:0] hsize, input logic [1:0] addr_lo);
        return (hsize == HSIZE_WORD) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/eva_ahb2apb_if.sv
// AHB-lite slave side and APB3 master side of the bridge in one bundle.
// slave  : the bridge's view.  master : the bus-function master / APB
// register-slave view used by the environment.
interface eva_ahb2apb_if #(
    parameter int PADDR_W = 16
);
    logic               hsel;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [31:0]        haddr;
    logic [2:0]         hsize;
    logic [31:0]        hwdata;
    logic               hready;
    logic               hreadyout;
    logic [1:0]         hresp;
    logic [31:0]        hrdata;

    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [PADDR_W-1:0] paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;

    modport slave (
        input  hsel, htrans, hwrite, haddr, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, htrans, hwrite, haddr, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/eva_apb_timeout.sv
// Saturating ACCESS-phase cycle counter. o_expired flags the cycle in which
// the count reaches TIMEOUT; TIMEOUT=0 disables the watchdog entirely.
module eva_apb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic hclk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int              CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles, clear on request, stick at LIMIT instead of wrapping.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            // Asserted when this enabled cycle is the one that brings the count to LIMIT.
            assign o_expired = i_en && (r_cnt >= (LIMIT - CW'(1)));
        end
    endgenerate

endmodule

// File: rtl/eva_ahb2apb.sv
// AHB-lite slave to APB3 master bridge. One single-beat word transfer at a
// time: AHB is held with wait states until the APB slave completes, errors
// are returned as the two-cycle AHB ERROR response.
module eva_ahb2apb
    import eva_ahb_pkg::*;
#(
    parameter int PADDR_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           hclk,
    input  logic           rst_n,
    eva_ahb2apb_if.slave   bus
);
    bridge_state_e      r_state;
    bridge_state_e      w_state_nxt;

    logic               r_hreadyout;
    logic [1:0]         r_hresp;
    logic [31:0]        r_hrdata;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [PADDR_W-1:0] r_paddr;
    logic [31:0]        r_pwdata;

    logic               w_req;
    logic               w_legal;
    logic               w_load;
    logic               w_expired;
    logic               w_rd_done;

    assign w_req     = bus.hsel && bus.hready && bus.htrans[1];
    assign w_legal   = is_legal_xfer(bus.hsize, bus.haddr[1:0]);
    assign w_rd_done = (r_state == ST_ACCESS) && bus.pready && !bus.pslverr && !r_pwrite;

    eva_apb_timeout #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .hclk      (hclk),
        .rst_n     (rst_n),
        .i_clr     (r_state == ST_SETUP),
        .i_en      (r_state == ST_ACCESS),
        .o_expired (w_expired)
    );

    // Next-state decode; a completed pready wins over an expiring watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (w_req) begin
                    if (w_legal) begin
                        w_load = 1'b1;
                        if (bus.hwrite) begin
                            w_state_nxt = ST_WLAT;
                        end else begin
                            w_state_nxt = ST_SETUP;
                        end
                    end else begin
                        w_state_nxt = ST_ERR1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WLAT:   w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.pready) begin
                    if (bus.pslverr) begin
                        w_state_nxt = ST_ERR1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_ERR1;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ERR1:   w_state_nxt = ST_ERR2;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State and all bus outputs registered from the state being entered.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= 32'h0000_0000;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_hreadyout <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR2);
            r_hresp     <= ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            r_psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
            r_penable   <= (w_state_nxt == ST_ACCESS);
            if (w_load) begin
                r_paddr  <= bus.haddr[PADDR_W-1:0];
                r_pwrite <= bus.hwrite;
            end
            if (r_state == ST_WLAT) begin
                r_pwdata <= bus.hwdata;
            end
            if (w_rd_done) begin
                r_hrdata <= bus.prdata;
            end
        end
    end

    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.hrdata    = r_hrdata;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_eva_ahb2apb.sv
// Scoreboard bench for eva_ahb2apb: stimulus pushes expected AHB responses
// and APB slave behaviour into queues; a monitor and an APB slave process
// check them independently.
module tb_eva_ahb2apb;
    import eva_ahb_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        slverr;
        logic        hang;
    } xfer_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic hclk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] model_hrdata = 32'h0;
    xfer_t plan_q[$];
    exp_t  exp_q[$];

    eva_ahb2apb_if #(.PADDR_W(16)) bus ();
    assign bus.hready = bus.hreadyout;

    eva_ahb2apb #(.PADDR_W(16), .TIMEOUT(TO)) dut (
        .hclk  (hclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic xfer_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int waits, input logic slverr, input logic hang);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.rdata = rdata;
        x.waits = waits; x.slverr = slverr; x.hang = hang;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r;
        int s;
        x = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 3'b010, $urandom, $urandom,
               $urandom_range(0, 3), 1'b0, 1'b0);
        r = $urandom_range(0, 99);
        x.slverr = (r < 10);
        x.hang   = (r >= 10) && (r < 15);
        if (r >= 15 && r < 22) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, 6);
                if (s >= 2) s++;
                x.size = 3'(s);
            end else begin
                x.addr[1:0] = 2'($urandom_range(1, 3));
            end
        end
        return x;
    endfunction

    // Reference model: AHB-visible outcome from the transfer's kind and APB behaviour.
    task automatic drive_addr(input xfer_t x, input bit want_exp);
        exp_t e;
        int   wl;
        wl = x.wr ? 1 : 0;
        bus.hsel   = 1'b1;
        bus.htrans = ($urandom_range(0, 1) == 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
        bus.hwrite = x.wr;
        bus.haddr  = x.addr;
        bus.hsize  = x.size;
        if (x.size != 3'b010 || x.addr[1:0] != 2'b00) begin
            e.resp  = HRESP_ERROR;
            e.waits = 1;
        end else begin
            plan_q.push_back(x);
            if (x.hang) begin
                e.resp  = HRESP_ERROR;
                e.waits = wl + 1 + TO + 1;
            end else if (x.slverr) begin
                e.resp  = HRESP_ERROR;
                e.waits = wl + 1 + (x.waits + 1) + 1;
            end else begin
                e.resp  = HRESP_OKAY;
                e.waits = wl + 1 + (x.waits + 1);
                if (!x.wr) model_hrdata = x.rdata;
            end
        end
        e.rdata = model_hrdata;
        if (want_exp) exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        bus.hsel   = 1'($urandom_range(0, 1));
        bus.htrans = ($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE;
        bus.hwrite = 1'($urandom_range(0, 1));
        bus.haddr  = $urandom;
        bus.hsize  = 3'b010;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.hreadyout && n < 100) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 100) fail_now("hready_timeout");
    endtask

    // Called at a negedge: address phase, accept, then data-phase hwdata.
    task automatic send(input xfer_t x, input int gap);
        drive_addr(x, 1'b1);
        wait_ready();
        @(posedge hclk);
        @(negedge hclk);
        bus.hwdata = x.wdata;
        drive_idle();
        repeat (gap) @(negedge hclk);
    endtask

    // APB register slave: follows the plan queue, checks address/data stability.
    initial begin : apb_slave
        xfer_t cur;
        int    cnt;
        bit    bad;
        cnt = 0;
        bad = 1'b0;
        cur = mk(1'b0, 32'h0, 3'b010, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'h0;
        forever begin
            @(negedge hclk);
            if (!rst_n) begin
                cnt = 0;
                bus.pready = 1'b0;
            end else if (bus.psel && bus.penable) begin
                if (cnt == 0) begin
                    if (plan_q.size() == 0) begin
                        fail_now("apb_access_unexpected");
                        bad = 1'b1;
                        cur.hang = 1'b1;
                    end else begin
                        cur = plan_q.pop_front();
                        bad = 1'b0;
                    end
                end
                if (!bad) begin
                    chk("paddr", {16'h0, bus.paddr}, {16'h0, cur.addr[15:0]});
                    chk("pwrite", {31'h0, bus.pwrite}, {31'h0, cur.wr});
                    if (cur.wr) chk("pwdata", bus.pwdata, cur.wdata);
                end
                if (cur.hang || cnt < cur.waits) begin
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'($urandom_range(0, 1));
                    bus.prdata  = $urandom;
                end else begin
                    bus.pready  = 1'b1;
                    bus.pslverr = cur.slverr;
                    bus.prdata  = cur.rdata;
                end
                cnt++;
            end else begin
                if (bus.psel && plan_q.size() == 0) fail_now("psel_unexpected");
                cnt = 0;
                bus.pready  = 1'($urandom_range(0, 1));
                bus.pslverr = 1'($urandom_range(0, 1));
                bus.prdata  = $urandom;
            end
        end
    end

    // AHB monitor: counts wait states per data phase and checks each completion.
    initial begin : monitor
        bit         in_data;
        int         waits;
        logic       prev_rdy;
        logic [1:0] last_resp;
        exp_t       e;
        in_data   = 1'b0;
        waits     = 0;
        prev_rdy  = 1'b1;
        last_resp = 2'b00;
        forever begin
            @(posedge hclk);
            #1;
            if (!rst_n) begin
                in_data  = 1'b0;
                prev_rdy = bus.hreadyout;
            end else begin
                if (prev_rdy && bus.hsel && bus.htrans[1]) begin
                    in_data = 1'b1;
                    waits   = 0;
                end
                if (in_data) begin
                    if (bus.hreadyout) begin
                        if (exp_q.size() == 0) begin
                            fail_now("completion_unexpected");
                        end else begin
                            e = exp_q.pop_front();
                            chk("hresp", {30'h0, bus.hresp}, {30'h0, e.resp});
                            chk("wait_states", 32'(waits), 32'(e.waits));
                            chk("hrdata", bus.hrdata, e.rdata);
                            if (waits > 0) chk("hresp_wait", {30'h0, last_resp}, {30'h0, e.resp});
                        end
                        in_data = 1'b0;
                    end else begin
                        waits++;
                        last_resp = bus.hresp;
                    end
                end
                prev_rdy = bus.hreadyout;
            end
        end
    end

    initial begin : stimulus
        xfer_t x;
        int    n;
        rst_n      = 1'b0;
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        bus.hwrite = 1'b0;
        bus.haddr  = 32'h0;
        bus.hsize  = 3'b010;
        bus.hwdata = 32'h0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hreadyout", {31'h0, bus.hreadyout}, 32'h1);
        chk("rst_hresp", {30'h0, bus.hresp}, 32'h0);
        chk("rst_hrdata", bus.hrdata, 32'h0);
        chk("rst_psel", {31'h0, bus.psel}, 32'h0);
        chk("rst_penable", {31'h0, bus.penable}, 32'h0);
        chk("rst_pwrite", {31'h0, bus.pwrite}, 32'h0);
        chk("rst_paddr", {16'h0, bus.paddr}, 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        @(negedge hclk);
        rst_n = 1'b1;
        @(negedge hclk);

        send(mk(1'b0, 32'h0000_0010, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0), 2);
        send(mk(1'b1, 32'h0000_0024, 3'b010, 32'h1234_5678, 32'h0, 3, 1'b0, 1'b0), 0);
        send(mk(1'b0, 32'hABCD_0100, 3'b010, 32'h0, 32'hA5A5_5A5A, 1, 1'b0, 1'b0), 1);
        send(mk(1'b0, 32'h0000_0010, 3'b000, 32'h0, 32'h0, 0, 1'b0, 1'b0), 0);
        send(mk(1'b1, 32'h0000_0002, 3'b010, 32'hFFFF_0000, 32'h0, 0, 1'b0, 1'b0), 0);
        send(mk(1'b0, 32'h0000_0040, 3'b010, 32'h0, 32'h1111_2222, 1, 1'b1, 1'b0), 0);
        send(mk(1'b0, 32'h0000_0044, 3'b010, 32'h0, 32'h3333_4444, 0, 1'b0, 1'b1), 0);
        send(mk(1'b0, 32'h0000_0010, 3'b010, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0), 2);

        for (int i = 0; i < 150; i++) begin
            send(rand_xfer(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");

        // Reset in the middle of an APB access.
        x = mk(1'b0, 32'h0000_0080, 3'b010, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        drive_addr(x, 1'b0);
        wait_ready();
        @(posedge hclk);
        @(negedge hclk);
        drive_idle();
        n = 0;
        while (!(bus.psel && bus.penable) && n < 50) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 50) fail_now("access_timeout");
        rst_n    = 1'b0;
        bus.hsel = 1'b0;
        @(posedge hclk);
        #1;
        chk("midrst_psel", {31'h0, bus.psel}, 32'h0);
        chk("midrst_penable", {31'h0, bus.penable}, 32'h0);
        chk("midrst_hreadyout", {31'h0, bus.hreadyout}, 32'h1);
        chk("midrst_hrdata", bus.hrdata, 32'h0);
        @(negedge hclk);
        rst_n = 1'b1;
        plan_q.delete();
        model_hrdata = 32'h0;
        @(negedge hclk);
        send(mk(1'b0, 32'h0000_0010, 3'b010, 32'h0, 32'hC0FF_EE00, 1, 1'b0, 1'b0), 2);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 100) fail_now("final_drain_timeout");
        repeat (2) @(negedge hclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eva_ahb2apb.md
# eva_ahb2apb

AHB-lite slave to APB3 master bridge. It consumes the word-sized, single-beat AHB transfers driven by the EVA DPI bus-function master and converts each one into an APB setup/access sequence toward the register slaves under test. The bridge inserts wait states on AHB until the APB slave completes, then returns read data or a two-cycle ERROR response. It also covers illegal transfers and APB slaves that hang.

## Interface
- PADDR_W, 16, APB address width; paddr = haddr[PADDR_W-1:0], upper haddr bits ignored
- TIMEOUT, 255, max ACCESS cycles waiting for pready; 0 disables the timeout
- hclk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock hclk
- hsel  in  1  slave select
- htrans  in  2  transfer type; IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- hwrite  in  1  1 = write
- haddr  in  32  byte address
- hsize  in  3  transfer size; only 3'b010 (word) is legal
- hwdata  in  32  write data, valid in the first data-phase cycle
- hready  in  1  bus-wide ready (previous transfer complete)
- hreadyout  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- hrdata  out  32  read data
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  PADDR_W  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready, pslverr  in  1 each  APB completion and error

## Operation
- Accept condition: hsel & hready & htrans[1]. Accept is evaluated only in IDLE or ERR2. IDLE/BUSY transfers get OKAY with zero wait states.
- On accept, latch the address (haddr[PADDR_W-1:0]) and hwrite.
- Illegal transfer: hsize != 3'b010 or haddr[1:0] != 0.
  - Go to ERR1. No APB access is issued.
- States:
  - IDLE: hreadyout=1, hresp=OKAY. Legal read → SETUP. Legal write → WLAT.
  - WLAT: hreadyout=0. Capture hwdata into pwdata → SETUP.
  - SETUP: psel=1, penable=0, hreadyout=0 → ACCESS.
  - ACCESS: psel=1, penable=1, hreadyout=0. Outcome on pready:
    - pready & !pslverr: read captures prdata into hrdata, then → IDLE.
    - pready & pslverr → ERR1.
    - Timeout counter reaches TIMEOUT → ERR1, and psel/penable are dropped.
  - ERR1: hreadyout=0, hresp=ERROR, psel=0 → ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. Same accept rules as IDLE; with no accept → IDLE.
- All outputs are registered and reflect the current state.
- paddr, pwrite and pwdata hold their values from SETUP through the end of ACCESS.
- hrdata changes only on a successful read; otherwise it holds its value.
- Timeout counter: clog2(TIMEOUT+1) bits. It clears on entry to ACCESS and saturates; it never wraps.

## Timing
- Reset (rst_n low at an edge): state=IDLE, hreadyout=1, hresp=OKAY, hrdata=0, psel=penable=pwrite=0, paddr=0, pwdata=0, counter=0.
- Reset mid-transfer drops psel at the next edge regardless of pready.
- Read, pready tied high: accept edge T0. T1 SETUP, T2 ACCESS, T3 IDLE with hreadyout=1 and hrdata valid. This gives 2 wait states.
- Write, pready tied high: T1 WLAT, T2 SETUP, T3 ACCESS, T4 IDLE. This gives 3 wait states.
- Each cycle of pready low in ACCESS adds one wait state.
- Back-to-back transfers: the next address phase is sampled in the IDLE/ERR2 completion cycle, so there are no idle cycles between transfers.
- Error: ERROR is signalled for exactly 2 cycles, first with hreadyout=0 and then with hreadyout=1.
- Timeout: with TIMEOUT=N and pready stuck low, ACCESS lasts N cycles, then ERR1.
- pslverr is ignored unless pready=1.

## Structure
- Package eva_ahb_pkg: htrans encodings, hresp encodings, HSIZE_WORD, and the bridge state enum (IDLE, WLAT, SETUP, ACCESS, ERR1, ERR2). This package is shared with later AHB blocks.
- One sub-module, eva_apb_timeout: saturating counter with clear/enable inputs and an expired output. TIMEOUT=0 ties expired to 0.
- Everything else lives in a single FSM module.

## Test plan
- Read, haddr=0x0000_0010, prdata=0xDEAD_BEEF, pready=1 → paddr=0x0010 in SETUP/ACCESS. hrdata=0xDEADBEEF with hreadyout=1 at T3, hresp=OKAY.
- Write, haddr=0x0000_0024, hwdata=0x1234_5678, pready low for 3 ACCESS cycles → pwdata=0x12345678 and pwrite=1. Completion at T7.
- Write followed immediately by a read (NONSEQ in the completion cycle) → second SETUP starts the cycle after IDLE. The read's prdata is returned, and the write data is unchanged on the APB bus until the write's ACCESS ends.
- hsize=3'b000, or haddr=0x0000_0002 → no psel, ERROR for 2 cycles (hreadyout 0 then 1). pslverr=1 on a legal read → the same 2-cycle ERROR, and hrdata is unchanged.
- TIMEOUT=4, pready stuck low → ACCESS for 4 cycles, psel drops, ERROR response. The next legal read with pready=1 completes normally.
- rst_n driven low during ACCESS → next edge gives psel=0, hreadyout=1, hrdata=0. A new read after reset succeeds.
